// File: rtl/dma_controller_pkg.sv
// Package: dma_controller_pkg
// Purpose: shared definitions for the DMA engine. It holds the FSM state
//          encoding, the bit positions of the command fields, the bus widths,
//          the default timing parameters and the ceil(len/LINE_WORDS) helper.
// Ports:   none (package)
package dma_controller_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_REQ     = 3'd2,
        ST_FETCH   = 3'd3,
        ST_WRITE   = 3'd4,
        ST_DONE    = 3'd5,
        ST_RELEASE = 3'd6
    } dma_state_t;

    // DMA_command layout: [15:12] length in words, [11:0] destination base.
    localparam int LEN_MSB  = 15;
    localparam int LEN_LSB  = 12;
    localparam int ADDR_MSB = 11;
    localparam int ADDR_LSB = 0;

    localparam int CMD_W   = 16;
    localparam int ADDR_W  = 16;
    localparam int LINE_W  = 64;
    localparam int IDX_W   = 4;
    localparam int LINES_W = 3;

    localparam int DEFAULT_LINE_WORDS   = 4;
    localparam int DEFAULT_WRITE_CYCLES = 4;

    // Number of whole lines needed to cover len words (rounded up).
    function automatic logic [LINES_W-1:0] lines_for_len(input logic [3:0] len,
                                                         input int line_words);
        int n;
        n = (int'(len) + line_words - 1) / line_words;
        return LINES_W'(n);
    endfunction

endpackage

// File: rtl/dma_controller.sv
// Module: dma_controller
// Purpose: bus-master DMA engine beside the cpu on the data-memory bus. After a
//          rising edge on DMA_begin it latches DMA_command, requests the bus,
//          and once granted copies device lines into data memory one line at a
//          time. When the transfer is complete it drops BR, pulses DMA_end and
//          waits for the grant to be withdrawn.
// Ports:
//   Clk          in   1   clock, all state on posedge
//   Reset_N      in   1   synchronous active-low reset
//   DMA_begin    in   1   start request (rising edge is what counts)
//   DMA_command  in   16  [15:12] length in words, [11:0] destination base
//   BR           out  1   bus request
//   BG           in   1   bus grant
//   DMA_end      out  1   one-cycle completion pulse
//   dev_rd       out  1   one-cycle device line request
//   dev_idx      out  4   device line index
//   dev_valid    in   1   dev_line holds the requested line
//   dev_line     in   64  device line data
//   d_writeM     out  1   memory write strobe, Z unless owning the bus
//   d_address    out  16  memory line address, Z unless owning the bus
//   d_data       inout 64 line data while owning the bus, else Z
module dma_controller
    import dma_controller_pkg::*;
#(
    parameter int WRITE_CYCLES = DEFAULT_WRITE_CYCLES,
    parameter int LINE_WORDS   = DEFAULT_LINE_WORDS
) (
    input  logic              Clk,
    input  logic              Reset_N,
    input  logic              DMA_begin,
    input  logic [CMD_W-1:0]  DMA_command,
    output logic              BR,
    input  logic              BG,
    output logic              DMA_end,
    output logic              dev_rd,
    output logic [IDX_W-1:0]  dev_idx,
    input  logic              dev_valid,
    input  logic [LINE_W-1:0] dev_line,
    output tri                d_writeM,
    output tri   [ADDR_W-1:0] d_address,
    inout  tri   [LINE_W-1:0] d_data
);

    localparam int CYC_W = (WRITE_CYCLES > 1) ? $clog2(WRITE_CYCLES) : 1;
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(WRITE_CYCLES - 1);

    dma_state_t          state_reg, state_next;
    logic                begin_prev_reg;
    logic [ADDR_W-1:0]   base_reg, base_next;
    logic [LINES_W-1:0]  lines_reg, lines_next;
    logic [LINES_W-1:0]  line_reg, line_next;
    logic [CYC_W-1:0]    cyc_reg, cyc_next;
    logic                fetch_wait_reg, fetch_wait_next;
    logic [LINE_W-1:0]   data_reg, data_next;

    logic [3:0]          cmd_len;
    logic [LINES_W-1:0]  cmd_lines;
    logic [LINES_W-1:0]  line_inc;
    logic                own_bus;

    assign cmd_len   = DMA_command[LEN_MSB:LEN_LSB];
    assign cmd_lines = lines_for_len(cmd_len, LINE_WORDS);
    assign line_inc  = line_reg + 1'b1;
    assign dev_idx   = IDX_W'(line_reg);

    // Ownership follows BG combinationally so a revoked grant releases the
    // bus in the same cycle, before the FSM has left WRITE.
    assign own_bus = (state_reg == ST_WRITE) && BG;

    assign d_writeM  = own_bus ? 1'b1 : 1'bz;
    assign d_address = own_bus ? (base_reg + ADDR_W'(line_reg) * ADDR_W'(LINE_WORDS))
                               : {ADDR_W{1'bz}};
    assign d_data    = own_bus ? data_reg : {LINE_W{1'bz}};

    always_comb begin
        state_next      = state_reg;
        base_next       = base_reg;
        lines_next      = lines_reg;
        line_next       = line_reg;
        cyc_next        = cyc_reg;
        fetch_wait_next = fetch_wait_reg;
        data_next       = data_reg;
        BR              = 1'b0;
        DMA_end         = 1'b0;
        dev_rd          = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                // Only a 0->1 transition starts a transfer; a level left high
                // after a previous transfer is ignored.
                if (DMA_begin && !begin_prev_reg) begin
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                base_next  = ADDR_W'(DMA_command[ADDR_MSB:ADDR_LSB]);
                lines_next = cmd_lines;
                line_next  = '0;
                state_next = (cmd_len == 4'd0) ? ST_DONE : ST_REQ;
            end
            ST_REQ: begin
                BR = 1'b1;
                if (BG) begin
                    fetch_wait_next = 1'b0;
                    state_next      = ST_FETCH;
                end
            end
            ST_FETCH: begin
                BR     = 1'b1;
                dev_rd = BG && !fetch_wait_reg;
                if (!BG) begin
                    state_next = ST_REQ;
                end else begin
                    fetch_wait_next = 1'b1;
                    // dev_valid in the request cycle itself may be stale from
                    // an earlier line, so it is only honoured afterwards.
                    if (fetch_wait_reg && dev_valid) begin
                        data_next  = dev_line;
                        cyc_next   = '0;
                        state_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                BR = 1'b1;
                if (!BG) begin
                    // Line counter is kept: the same line is refetched and
                    // rewritten in full after the grant returns.
                    state_next = ST_REQ;
                end else if (cyc_reg == CYC_LAST) begin
                    line_next = line_inc;
                    if (line_inc == lines_reg) begin
                        state_next = ST_DONE;
                    end else begin
                        fetch_wait_next = 1'b0;
                        state_next      = ST_FETCH;
                    end
                end else begin
                    cyc_next = cyc_reg + 1'b1;
                end
            end
            ST_DONE: begin
                DMA_end    = 1'b1;
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                // Hold off new commands until the stale grant has gone away.
                if (!BG) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // DMA_begin is sampled on every edge, reset included, so a level held
        // through reset is not mistaken for a fresh start request.
        begin_prev_reg <= DMA_begin;
        if (!Reset_N) begin
            state_reg      <= ST_IDLE;
            base_reg       <= '0;
            lines_reg      <= '0;
            line_reg       <= '0;
            cyc_reg        <= '0;
            fetch_wait_reg <= 1'b0;
            data_reg       <= '0;
        end else begin
            state_reg      <= state_next;
            base_reg       <= base_next;
            lines_reg      <= lines_next;
            line_reg       <= line_next;
            cyc_reg        <= cyc_next;
            fetch_wait_reg <= fetch_wait_next;
            data_reg       <= data_next;
        end
    end

endmodule

// File: tb/tb_dma_controller.sv
// Testbench: tb_dma_controller
// Purpose: directed tests of dma_controller with a small cpu grant model and
//          a device model; a recorder logs every memory write burst.
module tb_dma_controller;

    logic        Clk         = 1'b0;
    logic        Reset_N     = 1'b0;
    logic        DMA_begin   = 1'b0;
    logic [15:0] DMA_command = '0;
    logic        BR;
    logic        BG          = 1'b0;
    logic        DMA_end;
    logic        dev_rd;
    logic [3:0]  dev_idx;
    logic        dev_valid   = 1'b0;
    logic [63:0] dev_line    = '0;
    wire         d_writeM;
    wire  [15:0] d_address;
    wire  [63:0] d_data;

    int check_cnt = 0;
    int pass_cnt  = 0;

    dma_controller #(.WRITE_CYCLES(4), .LINE_WORDS(4)) dut (
        .Clk(Clk), .Reset_N(Reset_N), .DMA_begin(DMA_begin), .DMA_command(DMA_command),
        .BR(BR), .BG(BG), .DMA_end(DMA_end), .dev_rd(dev_rd), .dev_idx(dev_idx),
        .dev_valid(dev_valid), .dev_line(dev_line),
        .d_writeM(d_writeM), .d_address(d_address), .d_data(d_data)
    );

    always #5 Clk = ~Clk;

    // Device line contents: each 16-bit word is 0xDA5 followed by the index.
    function automatic logic [63:0] line_pat(input logic [3:0] idx);
        return {4{12'hDA5, idx}};
    endfunction

    // A released bus reads as Z (4-state) or 0 (2-state resolution).
    function automatic logic bus_released();
        return ((d_writeM === 1'b0) || (d_writeM === 1'bz)) &&
               ((d_address === 16'h0) || (d_address === 16'hzzzz)) &&
               ((d_data === 64'h0) || (d_data === {64{1'bz}}));
    endfunction

    // cpu grant model (BG follows BR one cycle late unless blocked) and
    // device model (line valid the cycle after dev_rd).
    logic       grant_block = 1'b0;
    logic       br_q        = 1'b0;
    logic       rd_pend     = 1'b0;
    logic [3:0] rd_idx      = '0;
    always begin
        @(posedge Clk);
        #1;
        BG = br_q && !grant_block;
        #1;
        br_q      = BR;
        dev_valid = rd_pend;
        dev_line  = rd_pend ? line_pat(rd_idx) : 64'h0;
        rd_pend   = (dev_rd === 1'b1);
        rd_idx    = dev_idx;
    end

    // Write-burst recorder.
    logic [15:0] wr_addr [0:63];
    logic [63:0] wr_data [0:63];
    int          wr_len  [0:63];
    int          wr_cnt     = 0;
    int          end_cnt    = 0;
    int          br_cycles  = 0;
    int          rd_cnt     = 0;
    logic        wm_prev    = 1'b0;
    always begin
        @(posedge Clk);
        #3;
        if (d_writeM === 1'b1) begin
            if (!wm_prev && wr_cnt < 64) begin
                wr_addr[wr_cnt] = d_address;
                wr_data[wr_cnt] = d_data;
                wr_len[wr_cnt]  = 1;
                wr_cnt++;
            end else if (wr_cnt > 0) begin
                wr_len[wr_cnt-1]++;
            end
            wm_prev = 1'b1;
        end else begin
            wm_prev = 1'b0;
        end
        if (DMA_end === 1'b1) end_cnt++;
        if (BR === 1'b1) br_cycles++;
        if (dev_rd === 1'b1) rd_cnt++;
    end

    task automatic tick();
        @(posedge Clk);
        #2;
    endtask

    // Rising edge on DMA_begin; returns in the CMD-state cycle.
    task automatic start_cmd(input logic [15:0] cmd);
        DMA_begin = 1'b0;
        tick();
        DMA_begin   = 1'b1;
        DMA_command = cmd;
        tick();
    endtask

    task automatic wait_end(input int budget, output logic seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (DMA_end === 1'b1) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        Reset_N = 1'b0;
        repeat (3) tick();
        check_cnt++; if (BR !== 1'b0) $display("FAIL reset_br: got %b want 0", BR); else pass_cnt++;
        check_cnt++; if (DMA_end !== 1'b0) $display("FAIL reset_end: got %b want 0", DMA_end); else pass_cnt++;
        check_cnt++; if (dev_rd !== 1'b0) $display("FAIL reset_dev_rd: got %b want 0", dev_rd); else pass_cnt++;
        check_cnt++; if (dev_idx !== 4'd0) $display("FAIL reset_dev_idx: got %0d want 0", dev_idx); else pass_cnt++;
        check_cnt++; if (bus_released() !== 1'b1) $display("FAIL reset_bus: got wm=%b addr=%h want released", d_writeM, d_address); else pass_cnt++;
        Reset_N = 1'b1;
        tick();
        check_cnt++; if (BR !== 1'b0) $display("FAIL reset_idle_br: got %b want 0", BR); else pass_cnt++;
        $display("test_reset done");
    endtask

    task automatic test_three_lines();
        int   w0, e0, b0;
        logic seen;
        logic [15:0] exp_a [0:2];
        exp_a[0] = 16'h01f4; exp_a[1] = 16'h01f8; exp_a[2] = 16'h01fc;
        w0 = wr_cnt; e0 = end_cnt;
        start_cmd(16'hc1f4);
        check_cnt++; if (BR !== 1'b0) $display("FAIL lat_br_cmd: got %b want 0", BR); else pass_cnt++;
        tick();
        check_cnt++; if (BR !== 1'b1) $display("FAIL lat_br_req: got %b want 1", BR); else pass_cnt++;
        wait_end(120, seen);
        check_cnt++; if (seen !== 1'b1) $display("FAIL three_timeout: got %b want 1", seen); else pass_cnt++;
        check_cnt++; if (BR !== 1'b0) $display("FAIL three_br_at_end: got %b want 0", BR); else pass_cnt++;
        repeat (4) tick();
        check_cnt++; if (wr_cnt - w0 !== 3) $display("FAIL three_nwrites: got %0d want 3", wr_cnt - w0); else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            check_cnt++; if (wr_addr[w0+k] !== exp_a[k]) $display("FAIL three_addr%0d: got %h want %h", k, wr_addr[w0+k], exp_a[k]); else pass_cnt++;
            check_cnt++; if (wr_data[w0+k] !== line_pat(4'(k))) $display("FAIL three_data%0d: got %h want %h", k, wr_data[w0+k], line_pat(4'(k))); else pass_cnt++;
            check_cnt++; if (wr_len[w0+k] !== 4) $display("FAIL three_len%0d: got %0d want 4", k, wr_len[w0+k]); else pass_cnt++;
        end
        check_cnt++; if (end_cnt - e0 !== 1) $display("FAIL three_end_pulses: got %0d want 1", end_cnt - e0); else pass_cnt++;
        // DMA_begin is still high: a level without a fresh edge must not restart.
        b0 = br_cycles;
        repeat (6) tick();
        check_cnt++; if (br_cycles - b0 !== 0) $display("FAIL level_restart: got %0d BR cycles want 0", br_cycles - b0); else pass_cnt++;
        check_cnt++; if (bus_released() !== 1'b1) $display("FAIL three_bus_after: got wm=%b addr=%h want released", d_writeM, d_address); else pass_cnt++;
        DMA_begin = 1'b0;
        $display("test_three_lines: %0d writes", wr_cnt - w0);
    endtask

    task automatic test_zero_len();
        int b0, r0, w0;
        b0 = br_cycles; r0 = rd_cnt; w0 = wr_cnt;
        start_cmd(16'h0100);
        DMA_begin = 1'b0;
        check_cnt++; if (DMA_end !== 1'b0) $display("FAIL zero_end_cmd: got %b want 0", DMA_end); else pass_cnt++;
        tick();
        check_cnt++; if (DMA_end !== 1'b1) $display("FAIL zero_end_done: got %b want 1", DMA_end); else pass_cnt++;
        tick();
        check_cnt++; if (DMA_end !== 1'b0) $display("FAIL zero_end_width: got %b want 0", DMA_end); else pass_cnt++;
        repeat (3) tick();
        check_cnt++; if (br_cycles - b0 !== 0) $display("FAIL zero_br: got %0d BR cycles want 0", br_cycles - b0); else pass_cnt++;
        check_cnt++; if ((rd_cnt - r0) + (wr_cnt - w0) !== 0) $display("FAIL zero_bus_activity: got %0d want 0", (rd_cnt - r0) + (wr_cnt - w0)); else pass_cnt++;
        $display("test_zero_len done");
    endtask

    task automatic test_ceil();
        int   w0;
        logic seen;
        w0 = wr_cnt;
        start_cmd(16'h5ff8);
        DMA_begin = 1'b0;
        wait_end(100, seen);
        check_cnt++; if (seen !== 1'b1) $display("FAIL ceil_timeout: got %b want 1", seen); else pass_cnt++;
        repeat (3) tick();
        check_cnt++; if (wr_cnt - w0 !== 2) $display("FAIL ceil_nwrites: got %0d want 2", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (wr_addr[w0] !== 16'h0ff8) $display("FAIL ceil_addr0: got %h want 0ff8", wr_addr[w0]); else pass_cnt++;
        check_cnt++; if (wr_addr[w0+1] !== 16'h0ffc) $display("FAIL ceil_addr1: got %h want 0ffc", wr_addr[w0+1]); else pass_cnt++;
        $display("test_ceil: %0d writes", wr_cnt - w0);
    endtask

    task automatic test_grant_withheld();
        int   w0;
        logic seen, quiet;
        w0 = wr_cnt;
        grant_block = 1'b1;
        start_cmd(16'h4100);
        DMA_begin = 1'b0;
        tick();
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (BR !== 1'b1 || dev_rd === 1'b1 || !bus_released()) quiet = 1'b0;
        end
        check_cnt++; if (quiet !== 1'b1) $display("FAIL withheld_quiet: got %b want 1", quiet); else pass_cnt++;
        check_cnt++; if (wr_cnt - w0 !== 0) $display("FAIL withheld_early_write: got %0d want 0", wr_cnt - w0); else pass_cnt++;
        grant_block = 1'b0;
        wait_end(60, seen);
        check_cnt++; if (seen !== 1'b1) $display("FAIL withheld_timeout: got %b want 1", seen); else pass_cnt++;
        repeat (3) tick();
        check_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL withheld_nwrites: got %0d want 1", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (wr_addr[w0] !== 16'h0100) $display("FAIL withheld_addr: got %h want 0100", wr_addr[w0]); else pass_cnt++;
        $display("test_grant_withheld: %0d writes", wr_cnt - w0);
    endtask

    task automatic test_revoke();
        int   w0, r0;
        logic seen, found;
        w0 = wr_cnt; r0 = rd_cnt;
        start_cmd(16'h8200);
        DMA_begin = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (d_writeM === 1'b1 && d_address === 16'h0204) found = 1'b1;
        end
        check_cnt++; if (found !== 1'b1) $display("FAIL revoke_reach_line1: got %b want 1", found); else pass_cnt++;
        tick();
        grant_block = 1'b1;
        tick();
        check_cnt++; if (bus_released() !== 1'b1) $display("FAIL revoke_bus_z: got wm=%b addr=%h want released", d_writeM, d_address); else pass_cnt++;
        check_cnt++; if (BR !== 1'b1) $display("FAIL revoke_br: got %b want 1", BR); else pass_cnt++;
        repeat (3) tick();
        grant_block = 1'b0;
        wait_end(60, seen);
        check_cnt++; if (seen !== 1'b1) $display("FAIL revoke_timeout: got %b want 1", seen); else pass_cnt++;
        repeat (3) tick();
        check_cnt++; if (wr_cnt - w0 !== 3) $display("FAIL revoke_nruns: got %0d want 3", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (wr_len[w0+1] !== 2) $display("FAIL revoke_cut_len: got %0d want 2", wr_len[w0+1]); else pass_cnt++;
        check_cnt++; if (wr_addr[w0+2] !== 16'h0204) $display("FAIL revoke_rewrite_addr: got %h want 0204", wr_addr[w0+2]); else pass_cnt++;
        check_cnt++; if (wr_data[w0+2] !== line_pat(4'd1)) $display("FAIL revoke_rewrite_data: got %h want %h", wr_data[w0+2], line_pat(4'd1)); else pass_cnt++;
        check_cnt++; if (wr_len[w0+2] !== 4) $display("FAIL revoke_rewrite_len: got %0d want 4", wr_len[w0+2]); else pass_cnt++;
        check_cnt++; if (rd_cnt - r0 !== 3) $display("FAIL revoke_fetches: got %0d want 3", rd_cnt - r0); else pass_cnt++;
        $display("test_revoke: %0d write runs", wr_cnt - w0);
    endtask

    task automatic test_reset_mid();
        int   w0, e0;
        logic seen, found;
        start_cmd(16'h8300);
        DMA_begin = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 60 && !found; i++) begin
            tick();
            if (d_writeM === 1'b1) found = 1'b1;
        end
        check_cnt++; if (found !== 1'b1) $display("FAIL rstmid_reach_write: got %b want 1", found); else pass_cnt++;
        e0 = end_cnt;
        Reset_N = 1'b0;
        tick();
        check_cnt++; if (BR !== 1'b0) $display("FAIL rstmid_br: got %b want 0", BR); else pass_cnt++;
        check_cnt++; if (bus_released() !== 1'b1) $display("FAIL rstmid_bus: got wm=%b addr=%h want released", d_writeM, d_address); else pass_cnt++;
        Reset_N = 1'b1;
        repeat (6) tick();
        check_cnt++; if (end_cnt - e0 !== 0) $display("FAIL rstmid_no_end: got %0d want 0", end_cnt - e0); else pass_cnt++;
        w0 = wr_cnt;
        start_cmd(16'h4400);
        DMA_begin = 1'b0;
        wait_end(60, seen);
        check_cnt++; if (seen !== 1'b1) $display("FAIL rstmid_restart_timeout: got %b want 1", seen); else pass_cnt++;
        repeat (3) tick();
        check_cnt++; if (wr_cnt - w0 !== 1) $display("FAIL rstmid_restart_nwrites: got %0d want 1", wr_cnt - w0); else pass_cnt++;
        check_cnt++; if (wr_addr[w0] !== 16'h0400) $display("FAIL rstmid_restart_addr: got %h want 0400", wr_addr[w0]); else pass_cnt++;
        check_cnt++; if (wr_data[w0] !== line_pat(4'd0)) $display("FAIL rstmid_restart_data: got %h want %h", wr_data[w0], line_pat(4'd0)); else pass_cnt++;
        $display("test_reset_mid: restart wrote %0d lines", wr_cnt - w0);
    endtask

    initial begin
        test_reset();
        test_three_lines();
        test_zero_len();
        test_ceil();
        test_grant_withheld();
        test_revoke();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion want finish");
        $fatal(1, "timeout");
    end

endmodule
